matrix_window_ctrl: RTL and testbench

Frame and window sequencer placed directly after the 5x5 16-bit window generator in the filter pipeline. It consumes the generator's delayed vs/hs/clken strobes and tracks column and row positions. It flags which cycles carry a fully populated 5x5 window and reports the window-centre coordinates. It also produces frame start/done pulses and sticky line/frame geometry errors for downstream kernels (median, erosion, tracker).

---
 rtl/matrix_window_ctrl.sv | 161 ++++++++++++++++
 tb/tb_matrix_window_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_window_ctrl.sv
// Frame/window sequencer behind the 5x5 window generator: tracks column/row,
// flags fully populated windows, reports centre coordinates and geometry errors.
module matrix_window_ctrl #(
    parameter logic [9:0] IMG_H = 10'd800,
    parameter logic [9:0] IMG_V = 10'd600,
    parameter logic [2:0] WIN   = 3'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m_vs,
    input  logic       m_hs,
    input  logic       m_clken,
    input  logic       err_clr,
    output logic       win_valid,
    output logic [9:0] win_x,
    output logic [9:0] win_y,
    output logic       win_border,
    output logic       frame_start,
    output logic       frame_done,
    output logic       line_err,
    output logic       frame_err,
    output logic       busy
);

    // state     | meaning
    // IDLE      | no frame in progress, waiting for m_vs rise
    // WAIT_LINE | frame started, waiting for first m_hs rise
    // ACTIVE    | inside a line, counting strobed pixels
    // LINE_GAP  | between lines, waiting for next m_hs rise
    typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, LINE_GAP} state_t;

    localparam logic [9:0] WIN10  = {7'd0, WIN};
    localparam logic [9:0] HALF   = {8'd0, WIN[2:1]};
    localparam logic [9:0] HALF1  = HALF + 10'd1;
    localparam logic [9:0] ROW_MIN = WIN10 - 10'd1;
    localparam logic [9:0] H_EDGE = IMG_H - HALF - 10'd1;
    localparam logic [9:0] V_EDGE = IMG_V - HALF - 10'd1;
    localparam logic [9:0] CNT_MAX = 10'd1023;

    state_t     state, state_nxt;
    logic [9:0] col, col_nxt, row, row_nxt;
    logic [9:0] col_inc, row_inc;
    logic       vs_q, hs_q, armed;
    logic       vs_rise, vs_fall, hs_rise, hs_fall;
    logic       pix;
    logic       win_valid_nxt, win_border_nxt;
    logic [9:0] win_x_nxt, win_y_nxt;
    logic       frame_start_nxt, frame_done_nxt;
    logic       line_err_nxt, frame_err_nxt, busy_nxt;

    // armed masks edge detection for the first cycle after reset so a level
    // already high at release is not mistaken for a rising edge
    assign vs_rise = armed &  m_vs & ~vs_q;
    assign vs_fall = armed & ~m_vs &  vs_q;
    assign hs_rise = armed &  m_hs & ~hs_q;
    assign hs_fall = armed & ~m_hs &  hs_q;

    assign col_inc = (col == CNT_MAX) ? col : col + 10'd1;
    assign row_inc = (row == CNT_MAX) ? row : row + 10'd1;

    always_comb begin
        state_nxt       = state;
        col_nxt         = col;
        row_nxt         = row;
        pix             = 1'b0;
        win_valid_nxt   = 1'b0;
        win_x_nxt       = win_x;
        win_y_nxt       = win_y;
        win_border_nxt  = win_border;
        frame_start_nxt = 1'b0;
        frame_done_nxt  = 1'b0;
        line_err_nxt    = line_err & ~err_clr;
        frame_err_nxt   = frame_err & ~err_clr;
        busy_nxt        = busy;

        if (vs_fall) begin
            if (busy) frame_err_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
        end else if (vs_rise) begin
            if (state != IDLE && row != 10'd0 && row != IMG_V) frame_err_nxt = 1'b1;
            frame_start_nxt = 1'b1;
            busy_nxt        = 1'b1;
            row_nxt         = 10'd0;
            col_nxt         = 10'd0;
            state_nxt       = WAIT_LINE;
        end else begin
            case (state)
                WAIT_LINE, LINE_GAP: begin
                    if (hs_rise) begin
                        state_nxt = ACTIVE;
                        pix       = m_clken;
                    end
                end
                ACTIVE: begin
                    if (hs_fall) begin
                        if (col != IMG_H) line_err_nxt = 1'b1;
                        col_nxt = 10'd0;
                        row_nxt = row_inc;
                        if (row_inc == IMG_V) begin
                            frame_done_nxt = 1'b1;
                            busy_nxt       = 1'b0;
                            state_nxt      = IDLE;
                        end else begin
                            state_nxt = LINE_GAP;
                        end
                    end else begin
                        pix = m_hs & m_clken;
                    end
                end
                default: ;
            endcase
        end

        if (pix) begin
            col_nxt        = col_inc;
            win_valid_nxt  = (col_inc >= WIN10) && (row >= ROW_MIN);
            win_x_nxt      = (col_inc >= HALF1) ? col_inc - HALF1 : 10'd0;
            win_y_nxt      = (row >= HALF) ? row - HALF : 10'd0;
            win_border_nxt = (win_x_nxt < HALF) || (win_x_nxt > H_EDGE) ||
                             (win_y_nxt < HALF) || (win_y_nxt > V_EDGE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= 10'd0;
            row         <= 10'd0;
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
            armed       <= 1'b0;
            win_valid   <= 1'b0;
            win_x       <= 10'd0;
            win_y       <= 10'd0;
            win_border  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            vs_q        <= m_vs;
            hs_q        <= m_hs;
            armed       <= 1'b1;
            win_valid   <= win_valid_nxt;
            win_x       <= win_x_nxt;
            win_y       <= win_y_nxt;
            win_border  <= win_border_nxt;
            frame_start <= frame_start_nxt;
            frame_done  <= frame_done_nxt;
            line_err    <= line_err_nxt;
            frame_err   <= frame_err_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Directed bench for matrix_window_ctrl on an 8x6 image: window flags and
// coordinates, frame pulses, sticky errors, err_clr priority and mid-frame reset.
module tb_matrix_window_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_vs = 1'b0, m_hs = 1'b0, m_clken = 1'b0, err_clr = 1'b0;
    logic       win_valid, win_border, frame_start, frame_done;
    logic       line_err, frame_err, busy;
    logic [9:0] win_x, win_y;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_valid = 0, cnt_start = 0, cnt_done = 0;
    int base_valid, base_start, base_done;
    bit exp_line_err;

    matrix_window_ctrl #(.IMG_H(10'd8), .IMG_V(10'd6), .WIN(3'd5)) dut (
        .clk(clk), .rst_n(rst_n), .m_vs(m_vs), .m_hs(m_hs), .m_clken(m_clken),
        .err_clr(err_clr), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
        .win_border(win_border), .frame_start(frame_start), .frame_done(frame_done),
        .line_err(line_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (win_valid === 1'b1) cnt_valid++;
        if (frame_start === 1'b1) cnt_start++;
        if (frame_done === 1'b1) cnt_done++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // one line at row r (0-based) with npix strobed pixels; 8x6 geometry constants
    task automatic drive_line(input int r, input int npix, input bit toggle, input bit clr_at_fall);
        int ex, ey;
        bit ev, eb;
        m_hs = 1'b0; m_clken = 1'b0;
        step(); step();
        for (int k = 1; k <= npix; k++) begin
            m_hs = 1'b1; m_clken = 1'b1;
            step();
            ev = (k >= 5) && (r >= 4);
            ex = (k >= 3) ? k - 3 : 0;
            ey = (r >= 2) ? r - 2 : 0;
            eb = (ex < 2) || (ex > 5) || (ey < 2) || (ey > 3);
            chk("win_valid", 32'(win_valid), 32'(ev));
            chk("win_x", 32'(win_x), 32'(ex));
            chk("win_y", 32'(win_y), 32'(ey));
            chk("win_border", 32'(win_border), 32'(eb));
            if (toggle && k < npix) begin
                m_clken = 1'b0;
                step();
                chk("gap_valid", 32'(win_valid), 32'd0);
                chk("gap_x_hold", 32'(win_x), 32'(ex));
            end
        end
        m_hs = 1'b0; m_clken = 1'b0; err_clr = clr_at_fall;
        if (npix != 8) exp_line_err = 1'b1;
        step();
        err_clr = 1'b0;
        chk("line_err", 32'(line_err), 32'(exp_line_err));
        chk("frame_done", 32'(frame_done), (r == 5) ? 32'd1 : 32'd0);
        chk("busy", 32'(busy), (r == 5) ? 32'd0 : 32'd1);
    endtask

    task automatic start_frame();
        m_vs = 1'b1;
        step();
        chk("frame_start", 32'(frame_start), 32'd1);
        chk("busy_start", 32'(busy), 32'd1);
        step();
        chk("frame_start_pulse", 32'(frame_start), 32'd0);
    endtask

    initial begin
        exp_line_err = 1'b0;
        step(); step();
        chk("rst_valid", 32'(win_valid), 32'd0);
        chk("rst_x", 32'(win_x), 32'd0);
        chk("rst_y", 32'(win_y), 32'd0);
        chk("rst_border", 32'(win_border), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_lerr", 32'(line_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // full frame, continuous clken
        base_valid = cnt_valid; base_start = cnt_start; base_done = cnt_done;
        start_frame();
        for (int r = 0; r < 6; r++) drive_line(r, 8, 1'b0, 1'b0);
        step();
        chk("frame_done_pulse", 32'(frame_done), 32'd0);
        m_vs = 1'b0;
        step();
        chk("f1_valid_count", 32'(cnt_valid - base_valid), 32'd8);
        chk("f1_start_count", 32'(cnt_start - base_start), 32'd1);
        chk("f1_done_count", 32'(cnt_done - base_done), 32'd1);
        chk("f1_frame_err", 32'(frame_err), 32'd0);

        // same frame with clken toggling
        base_valid = cnt_valid;
        start_frame();
        for (int r = 0; r < 6; r++) drive_line(r, 8, 1'b1, 1'b0);
        m_vs = 1'b0;
        step();
        chk("f2_valid_count", 32'(cnt_valid - base_valid), 32'd8);
        chk("f2_line_err", 32'(line_err), 32'd0);
        chk("f2_frame_err", 32'(frame_err), 32'd0);

        // row 2 shortened to 7 pixels
        start_frame();
        for (int r = 0; r < 6; r++) drive_line(r, (r == 2) ? 7 : 8, 1'b0, 1'b0);
        m_vs = 1'b0;
        step();
        chk("f3_line_err_sticky", 32'(line_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_line_err = 1'b0;
        chk("f3_line_err_clr", 32'(line_err), 32'd0);

        // m_vs drops after 4 lines
        base_done = cnt_done;
        start_frame();
        for (int r = 0; r < 4; r++) drive_line(r, 8, 1'b0, 1'b0);
        m_vs = 1'b0;
        step();
        chk("f4_frame_err", 32'(frame_err), 32'd1);
        chk("f4_busy", 32'(busy), 32'd0);
        chk("f4_no_done", 32'(cnt_done - base_done), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("f4_ferr_clr", 32'(frame_err), 32'd0);

        // restart at row 0; short line with err_clr on the same cycle
        start_frame();
        drive_line(0, 5, 1'b0, 1'b1);
        chk("f5_set_over_clr", 32'(line_err), 32'd1);
        drive_line(1, 8, 1'b0, 1'b0);
        drive_line(2, 8, 1'b0, 1'b0);

        // reset mid-row 3 at col=5
        m_hs = 1'b0; m_clken = 1'b0;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            m_hs = 1'b1; m_clken = 1'b1;
            step();
        end
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(win_valid), 32'd0);
        chk("mrst_x", 32'(win_x), 32'd0);
        chk("mrst_y", 32'(win_y), 32'd0);
        chk("mrst_lerr", 32'(line_err), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        step(); step();
        rst_n = 1'b1;
        base_valid = cnt_valid; base_start = cnt_start; base_done = cnt_done;
        for (int k = 0; k < 3; k++) step();
        m_hs = 1'b0; m_clken = 1'b0;
        step(); step();
        for (int l = 0; l < 3; l++) begin
            m_hs = 1'b1; m_clken = 1'b1;
            for (int k = 0; k < 8; k++) step();
            m_hs = 1'b0; m_clken = 1'b0;
            step(); step();
        end
        chk("post_rst_no_valid", 32'(cnt_valid - base_valid), 32'd0);
        chk("post_rst_no_start", 32'(cnt_start - base_start), 32'd0);
        chk("post_rst_no_done", 32'(cnt_done - base_done), 32'd0);
        m_vs = 1'b0;
        step();
        chk("post_rst_ferr", 32'(frame_err), 32'd0);
        m_vs = 1'b1;
        step();
        chk("post_rst_fstart", 32'(frame_start), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
